// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780 write sequencer.
//   lcd_state_t      - write FSM state encoding
//   LCD_* constants  - the HD44780 command bytes the block cares about
//   INIT_TABLE       - power-up initialisation bytes, written in index order
//   helpers          - cycle-count clamping and clear/home wait detection
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_INIT,
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_PULSE,
        ST_WAIT
    } lcd_state_t;

    localparam logic [7:0] LCD_CLEAR        = 8'h01;
    localparam logic [7:0] LCD_HOME         = 8'h02;
    localparam logic [7:0] LCD_FUNC_8BIT_2L = 8'h38;
    localparam logic [7:0] LCD_DISP_ON      = 8'h0C;
    localparam logic [7:0] LCD_ENTRY_INC    = 8'h06;

    localparam int INIT_LEN = 6;
    localparam logic [7:0] INIT_TABLE [INIT_LEN] = '{
        LCD_FUNC_8BIT_2L, LCD_FUNC_8BIT_2L, LCD_FUNC_8BIT_2L,
        LCD_DISP_ON, LCD_ENTRY_INC, LCD_CLEAR
    };

    // A zero-length phase would never see the counter reach 1, so clamp to 1.
    function automatic int cyc_eff(input int c);
        return (c < 1) ? 1 : c;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clear and return-home (0x01, and 0x02/0x03 which the controller treats
    // as home) need the long execution wait; everything else uses the short one.
    function automatic logic needs_long_wait(input logic rs, input logic [7:0] b);
        return !rs && (b == LCD_CLEAR || b == LCD_HOME || b == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// lcd_delay_timer: loadable down-counter shared by every FSM phase.
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - load load_val this cycle (takes priority over counting)
//   load_val    - phase length in cycles
//   done        - high while the count is 1, i.e. the last cycle of the phase
module lcd_delay_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             cnt <= '0;
        else if (load)          cnt <= load_val;
        else if (cnt != '0)     cnt <= cnt - 1'b1;
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/lcd_writer.sv
// lcd_writer: byte-level HD44780 write sequencer.
//   CLOCK_50, RESET_N      - clock, asynchronous active-low reset
//   in_valid/in_rs/in_data - byte offered by upstream (rs: 0 cmd, 1 data)
//   in_ready               - high only in IDLE; a byte is taken on valid&&ready
//   RS, E, D               - LCD bus, all registered
// Build option: define LCD_INIT_EN to run the power-up delay and the
// initialisation table after every reset before accepting traffic.
// Each write is LOAD/INIT (1 cycle) + SETUP + PULSE (E high) + WAIT.
module lcd_writer import lcd_pkg::*; #(
    parameter int SETUP_CYCLES      = 3,
    parameter int E_PULSE_CYCLES    = 25,
    parameter int CMD_WAIT_CYCLES   = 2500,
    parameter int CLEAR_WAIT_CYCLES = 82000,
    parameter int POWERUP_CYCLES    = 750000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       in_valid,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       RS,
    output logic       E,
    output logic [7:0] D
);
    localparam int MAX_CYC = max_int(max_int(max_int(cyc_eff(SETUP_CYCLES),
                                     cyc_eff(E_PULSE_CYCLES)),
                                     max_int(cyc_eff(CMD_WAIT_CYCLES),
                                     cyc_eff(CLEAR_WAIT_CYCLES))),
                                     cyc_eff(POWERUP_CYCLES));
    localparam int CW = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] LD_SETUP = CW'(cyc_eff(SETUP_CYCLES));
    localparam logic [CW-1:0] LD_PULSE = CW'(cyc_eff(E_PULSE_CYCLES));
    localparam logic [CW-1:0] LD_CMD   = CW'(cyc_eff(CMD_WAIT_CYCLES));
    localparam logic [CW-1:0] LD_CLEAR = CW'(cyc_eff(CLEAR_WAIT_CYCLES));

    lcd_state_t    state, nxt;
    logic          tmr_load, tmr_done;
    logic [CW-1:0] tmr_val;
    logic          pend_rs;
    logic [7:0]    pend_d;
    logic          init_done;
    logic          accept;

    assign accept = (state == ST_IDLE) && in_valid && in_ready;

`ifdef LCD_INIT_EN
    localparam logic [CW-1:0] LD_POWERUP = CW'(cyc_eff(POWERUP_CYCLES));
    localparam lcd_state_t RESET_STATE = ST_POWERUP;

    logic [2:0] init_idx;
    // The counter comes out of reset at 0, so the first POWERUP cycle loads it.
    logic       pu_start;

    assign init_done = (init_idx == 3'(INIT_LEN));

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            init_idx <= '0;
            pu_start <= 1'b1;
        end else begin
            pu_start <= 1'b0;
            if (state == ST_INIT && nxt == ST_SETUP) init_idx <= init_idx + 1'b1;
        end
    end
`else
    localparam lcd_state_t RESET_STATE = ST_IDLE;
    assign init_done = 1'b1;
`endif

    always_comb begin
        nxt      = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
`ifdef LCD_INIT_EN
            ST_POWERUP: begin
                if (pu_start) begin
                    tmr_load = 1'b1;
                    tmr_val  = LD_POWERUP;
                end else if (tmr_done) begin
                    nxt = ST_INIT;
                end
            end
            ST_INIT:  nxt = init_done ? ST_IDLE : ST_SETUP;
`endif
            ST_IDLE:  if (accept) nxt = ST_LOAD;
            ST_LOAD:  nxt = ST_SETUP;
            ST_SETUP: if (tmr_done) nxt = ST_PULSE;
            ST_PULSE: if (tmr_done) nxt = ST_WAIT;
            ST_WAIT:  if (tmr_done) nxt = init_done ? ST_IDLE : ST_INIT;
            default:  nxt = ST_IDLE;
        endcase
        // Every state change reloads the counter; RS/D already hold the byte
        // being written, so the wait length can be chosen from them.
        if (nxt != state) begin
            tmr_load = 1'b1;
            case (nxt)
                ST_SETUP: tmr_val = LD_SETUP;
                ST_PULSE: tmr_val = LD_PULSE;
                ST_WAIT:  tmr_val = needs_long_wait(RS, D) ? LD_CLEAR : LD_CMD;
                default:  tmr_val = '0;
            endcase
        end
    end

    lcd_delay_timer #(.W(CW)) u_timer (
        .clk      (CLOCK_50),
        .rst_n    (RESET_N),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Outputs follow the next state so they line up with the state register.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= RESET_STATE;
            in_ready <= 1'b0;
            E        <= 1'b0;
            RS       <= 1'b0;
            D        <= 8'h00;
            pend_rs  <= 1'b0;
            pend_d   <= 8'h00;
        end else begin
            state    <= nxt;
            in_ready <= (nxt == ST_IDLE);
            E        <= (nxt == ST_PULSE);
            if (accept) begin
                pend_rs <= in_rs;
                pend_d  <= in_data;
            end
            // RS/D change only on SETUP entry and are held until the next one.
            if (nxt == ST_SETUP && state != ST_SETUP) begin
`ifdef LCD_INIT_EN
                if (state == ST_INIT) begin
                    RS <= 1'b0;
                    D  <= INIT_TABLE[init_idx];
                end else begin
                    RS <= pend_rs;
                    D  <= pend_d;
                end
`else
                RS <= pend_rs;
                D  <= pend_d;
`endif
            end
        end
    end

endmodule

// File: tb/tb_lcd_writer.sv
module tb_lcd_writer;
    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_rs    = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_ready, RS, E;
    logic [7:0] D;

    int checks   = 0;
    int failures = 0;

    lcd_writer #(
        .SETUP_CYCLES(2), .E_PULSE_CYCLES(4), .CMD_WAIT_CYCLES(10),
        .CLEAR_WAIT_CYCLES(30), .POWERUP_CYCLES(20)
    ) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .in_valid(in_valid),
        .in_rs(in_rs), .in_data(in_data), .in_ready(in_ready),
        .RS(RS), .E(E), .D(D)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         exp_rise;
        int         exp_fall;
        int         exp_ready;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_ready();
        for (int c = 0; c < 300 && !in_ready; c++) @(negedge CLOCK_50);
        if (!in_ready) chk("ready_timeout", in_ready, 1);
    endtask

    // Called at a negedge with in_ready high. Index k = sample after edge k,
    // edge 0 being the acceptance edge.
    task automatic run_write(input logic rs, input logic [7:0] dat,
                             output int rise, output int fall, output int rdy,
                             output logic rs1, output logic [7:0] d1,
                             output logic [7:0] d_end);
        rise = -1; fall = -1; rdy = -1; rs1 = 1'b0; d1 = 8'h00; d_end = 8'h00;
        in_valid = 1'b1; in_rs = rs; in_data = dat;
        @(negedge CLOCK_50);
        in_valid = 1'b0;
        for (int k = 0; k < 100 && rdy < 0; k++) begin
            if (k > 0) @(negedge CLOCK_50);
            if (k == 1) begin rs1 = RS; d1 = D; end
            if (E && rise < 0) rise = k;
            if (!E && rise >= 0 && fall < 0) fall = k;
            if (in_ready && rdy < 0) begin rdy = k; d_end = D; end
        end
    endtask

`ifdef LCD_INIT_EN
    task automatic check_init();
        logic [7:0] exp_tab [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
        logic [7:0] dv [6];
        logic       rsv [6];
        int e_hi = 0, pulses = 0, t_fall = -1, t_rdy = -1;
        logic prev_e = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLOCK_50);
            if (E || in_ready) e_hi++;
        end
        chk("powerup_quiet", e_hi, 0);
        for (int i = 0; i < 6; i++) begin dv[i] = 8'h00; rsv[i] = 1'b1; end
        for (int c = 0; c < 400 && t_rdy < 0; c++) begin
            @(negedge CLOCK_50);
            if (E && !prev_e) begin
                if (pulses < 6) begin dv[pulses] = D; rsv[pulses] = RS; end
                pulses++;
            end
            if (!E && prev_e && pulses == 6) t_fall = c;
            if (in_ready) t_rdy = c;
            prev_e = E;
        end
        chk("init_pulses", pulses, 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("init_d%0d", i), int'(dv[i]), int'(exp_tab[i]));
            chk($sformatf("init_rs%0d", i), int'(rsv[i]), 0);
        end
        chk("init_clear_wait", (t_fall < 0 || t_rdy < 0) ? -1 : t_rdy - t_fall, 30);
    endtask
`endif

    initial begin
        vec_t vecs [8];
        int rise, fall, rdy, pulses, e_hi;
        logic rs1, prev_e, will_acc;
        logic [7:0] d1, d_end;
        logic [7:0] dseen [4];
        logic [7:0] b2b [2];
        int ptr;

        vecs[0] = '{1'b1, 8'h41, 3, 7, 17};
        vecs[1] = '{1'b0, 8'h01, 3, 7, 37};
        vecs[2] = '{1'b0, 8'h00, 3, 7, 17};
        vecs[3] = '{1'b0, 8'h02, 3, 7, 37};
        vecs[4] = '{1'b0, 8'h03, 3, 7, 37};
        vecs[5] = '{1'b0, 8'h04, 3, 7, 17};
        vecs[6] = '{1'b1, 8'h01, 3, 7, 17};
        vecs[7] = '{1'b0, 8'h38, 3, 7, 17};

        // Reset values
        #2 RESET_N = 1'b0;
        #20;
        chk("rst_rs", RS, 0);
        chk("rst_e", E, 0);
        chk("rst_d", D, 0);
        chk("rst_ready", in_ready, 0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;

`ifdef LCD_INIT_EN
        check_init();
`else
        @(negedge CLOCK_50);
        chk("ready_first_clk", in_ready, 1);
        e_hi = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLOCK_50);
            if (E) e_hi++;
        end
        chk("no_spurious_e", e_hi, 0);
`endif

        // Single writes from the vector table
        for (int i = 0; i < 8; i++) begin
            wait_ready();
            run_write(vecs[i].rs, vecs[i].data, rise, fall, rdy, rs1, d1, d_end);
            chk($sformatf("v%0d_rs", i), rs1, vecs[i].rs);
            chk($sformatf("v%0d_d", i), d1, vecs[i].data);
            chk($sformatf("v%0d_e_rise", i), rise, vecs[i].exp_rise);
            chk($sformatf("v%0d_e_fall", i), fall, vecs[i].exp_fall);
            chk($sformatf("v%0d_ready", i), rdy, vecs[i].exp_ready);
            chk($sformatf("v%0d_d_held", i), d_end, vecs[i].data);
        end

        // Back-to-back with in_valid held high across both bytes
        wait_ready();
        b2b[0] = 8'h31; b2b[1] = 8'h32;
        for (int i = 0; i < 4; i++) dseen[i] = 8'h00;
        pulses = 0; ptr = 0; prev_e = E;
        in_valid = 1'b1; in_rs = 1'b1; in_data = b2b[0];
        for (int c = 0; c < 120; c++) begin
            will_acc = in_valid && in_ready;
            @(negedge CLOCK_50);
            if (E && !prev_e) begin
                if (pulses < 4) dseen[pulses] = D;
                pulses++;
            end
            prev_e = E;
            if (will_acc) begin
                ptr++;
                if (ptr < 2) in_data = b2b[ptr];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("b2b_pulses", pulses, 2);
        chk("b2b_d0", dseen[0], 8'h31);
        chk("b2b_d1", dseen[1], 8'h32);

        // Reset while E is high
        wait_ready();
        in_valid = 1'b1; in_rs = 1'b1; in_data = 8'h55;
        @(negedge CLOCK_50);
        in_valid = 1'b0;
        for (int c = 0; c < 50 && !E; c++) @(negedge CLOCK_50);
        chk("pre_reset_e", E, 1);
        #2 RESET_N = 1'b0;
        #1;
        chk("async_e_drop", E, 0);
        chk("async_ready", in_ready, 0);
        chk("async_d", D, 0);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
`ifdef LCD_INIT_EN
        check_init();
`else
        @(negedge CLOCK_50);
        chk("ready_after_rst", in_ready, 1);
        e_hi = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLOCK_50);
            if (E) e_hi++;
        end
        chk("no_e_after_rst", e_hi, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
